// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync/bright decodes and line/frame ticks from a divided pixel strobe.
// Optional frameCount output when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_START = 144,
    parameter int unsigned H_END   = 783,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_START = 35,
    parameter int unsigned V_END   = 514
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixEn,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       lineTick,
    output logic       frameTick
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frameCount
`endif
);
    logic [3:0] div_cnt;
    logic       h_last;
    logic       v_last;
    assign pixEn  = div_cnt == 4'(CLK_DIV - 1);
    assign h_last = hCount == 10'(H_TOTAL - 1);
    assign v_last = vCount == 10'(V_TOTAL - 1);
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt   <= '0;
            hCount    <= '0;
            vCount    <= '0;
            lineTick  <= 1'b0;
            frameTick <= 1'b0;
        end else begin
            div_cnt   <= pixEn ? '0 : div_cnt + 4'd1;
            lineTick  <= pixEn && h_last;
            frameTick <= pixEn && h_last && v_last;
            if (pixEn) begin
                hCount <= h_last ? '0 : hCount + 10'd1;
                if (h_last)
                    vCount <= v_last ? '0 : vCount + 10'd1;
            end
        end
    end
`ifdef VGA_FRAME_COUNT_EN
    // Advances on the same edge that wraps the raster to (0,0); wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset)
            frameCount <= '0;
        else if (pixEn && h_last && v_last)
            frameCount <= frameCount + 16'd1;
    end
`endif
    assign hSync  = !(hCount < 10'(H_SYNC));
    assign vSync  = !(vCount < 10'(V_SYNC));
    assign bright = hCount >= 10'(H_START) && hCount <= 10'(H_END) &&
                    vCount >= 10'(V_START) && vCount <= 10'(V_END);
endmodule
